// File: rtl/snapshot_checkpoint_ctrl.sv
// snapshot_checkpoint_ctrl
// Allocates register-file snapshot slots for predicted branches. Slots form a
// circular queue: head is the oldest outstanding slot and tail is the next free
// slot. A correct resolve frees the oldest slot. A mispredict restores the
// oldest slot and flushes every younger one through a two-cycle
// RESTORE/RECOVER sequence.
// Optional feature macro: CKPT_STATS_EN adds saturating statistics counters.
module snapshot_checkpoint_ctrl #(
    parameter int unsigned NUM_CKPT = 4,
    parameter int unsigned ID_W     = $clog2(NUM_CKPT)
`ifdef CKPT_STATS_EN
    ,
    parameter int unsigned STAT_W   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req,
    output logic                alloc_ack,
    output logic [ID_W-1:0]     alloc_id,
    output logic [NUM_CKPT-1:0] snap_take,
    output logic                ckpt_full,
    input  logic                resolve_valid,
    input  logic                resolve_mispred,
    output logic                restore_en,
    output logic [ID_W-1:0]     restore_id,
    output logic                recover_busy,
    output logic                protocol_err
`ifdef CKPT_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_alloc,
    output logic [STAT_W-1:0]   stat_mispred,
    output logic [STAT_W-1:0]   stat_full_stall
`endif
);

    localparam int unsigned CntW = $clog2(NUM_CKPT + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(NUM_CKPT);

    typedef enum logic [1:0] {
        StIdle,
        StRestore,
        StRecover
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] head_q, head_d;
    logic [ID_W-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q;
    logic            restore_en_q;
    logic [ID_W-1:0] restore_id_q, restore_id_d;
    logic            recover_busy_q;
    logic            protocol_err_q, protocol_err_d;

    logic is_idle;
    logic has_ckpt;
    logic mispred_any;
    logic do_alloc;
    logic do_free;
    logic do_mispred;
    logic bad_resolve;

    // Decode this cycle's events from inputs and current state.
    always_comb begin
        is_idle     = (state_q == StIdle);
        has_ckpt    = (count_q != '0);
        mispred_any = resolve_valid & resolve_mispred;
        do_mispred  = mispred_any & has_ckpt & is_idle;
        do_free     = resolve_valid & ~resolve_mispred & has_ckpt & is_idle;
        bad_resolve = resolve_valid & (~has_ckpt | ~is_idle);
        // Any mispredict indication drops the same-cycle request as wrong-path;
        // gating with rst_n keeps the grant low while reset is asserted.
        do_alloc    = rst_n & alloc_req & ~full_q & is_idle & ~mispred_any;
    end

    // Combinational grant and one-hot capture strobe.
    always_comb begin
        alloc_ack = do_alloc;
        alloc_id  = tail_q;
        snap_take = '0;
        if (do_alloc) begin
            snap_take[tail_q] = 1'b1;
        end
    end

    // Pointer, occupancy and sticky-error next state.
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        restore_id_d   = restore_id_q;
        protocol_err_d = protocol_err_q | bad_resolve;
        if (do_mispred) begin
            // Everything younger than head is wrong-path; rewind tail onto head.
            restore_id_d = head_q;
            tail_d       = head_q;
            count_d      = '0;
        end else begin
            if (do_alloc) begin
                tail_d = tail_q + 1'b1;
            end
            if (do_free) begin
                head_d = head_q + 1'b1;
            end
            if (do_alloc && !do_free) begin
                count_d = count_q + 1'b1;
            end else if (do_free && !do_alloc) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Recovery FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (do_mispred) state_d = StRestore;
            StRestore: state_d = StRecover;
            StRecover: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State and registered outputs; status flags are loaded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            restore_en_q   <= 1'b0;
            restore_id_q   <= '0;
            recover_busy_q <= 1'b0;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            full_q         <= (count_d == FullCnt);
            restore_en_q   <= (state_d == StRestore);
            restore_id_q   <= restore_id_d;
            recover_busy_q <= (state_d != StIdle);
            protocol_err_q <= protocol_err_d;
        end
    end

    always_comb begin
        ckpt_full    = full_q;
        restore_en   = restore_en_q;
        restore_id   = restore_id_q;
        recover_busy = recover_busy_q;
        protocol_err = protocol_err_q;
    end

`ifdef CKPT_STATS_EN
    logic [STAT_W-1:0] stat_alloc_q;
    logic [STAT_W-1:0] stat_mispred_q;
    logic [STAT_W-1:0] stat_full_stall_q;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_alloc_q      <= '0;
            stat_mispred_q    <= '0;
            stat_full_stall_q <= '0;
        end else begin
            if (do_alloc && (stat_alloc_q != '1)) begin
                stat_alloc_q <= stat_alloc_q + 1'b1;
            end
            if (do_mispred && (stat_mispred_q != '1)) begin
                stat_mispred_q <= stat_mispred_q + 1'b1;
            end
            if (alloc_req && full_q && (stat_full_stall_q != '1)) begin
                stat_full_stall_q <= stat_full_stall_q + 1'b1;
            end
        end
    end

    always_comb begin
        stat_alloc      = stat_alloc_q;
        stat_mispred    = stat_mispred_q;
        stat_full_stall = stat_full_stall_q;
    end
`endif

endmodule
